// File: rtl/register_window_mapper.sv
// register_window_mapper
//
// Front end of the 3-port register file. Translates 5-bit architectural SPARC
// register numbers into physical register-file indices using the current
// window pointer (CWP). Also holds CWP and WIM, executes SAVE/RESTORE, and
// raises window overflow/underflow traps that stay pending until trap_ack.
//
// Physical layout: indices 0..7 are the globals. Window w occupies
// base(w) = 8 + 16*w: base+0..7 are its ins, base+8..15 its locals. The outs
// of window w are the ins of window (w-1) mod NWINDOWS.
//
// Optional build macro:
//   RWM_TRAP_CNT_EN - when defined, ovf_cnt/unf_cnt count trap entries
//                     (saturating at 255). When undefined they are tied to 0
//                     and no counter flops exist.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rs1, rs2, rs3, rd     architectural register numbers
//   we_in                 destination write request
//   save, restore         window move requests
//   cwp_we, cwp_in        direct CWP load (out-of-range values ignored)
//   wim_we, wim_in        WIM load
//   trap_ack              clears a pending trap
//   pa/pb/pd/pw_idx       physical indices for rs1/rs2/rs3/rd
//   le_out                gated register-file write enable
//   cwp, wim              current window pointer / window invalid mask
//   trap, trap_type       pending trap flag and cause (01 ovf, 10 unf)
//   ovf_cnt, unf_cnt      trap entry counters

module register_window_mapper #(
  parameter int unsigned NWINDOWS = 8,
  parameter int unsigned CWP_W    = 3,
  parameter int unsigned PADDR_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [4:0]          rs3,
  input  logic [4:0]          rd,
  input  logic                we_in,
  input  logic                save,
  input  logic                restore,
  input  logic                cwp_we,
  input  logic [CWP_W-1:0]    cwp_in,
  input  logic                wim_we,
  input  logic [NWINDOWS-1:0] wim_in,
  input  logic                trap_ack,
  output logic [PADDR_W-1:0]  pa_idx,
  output logic [PADDR_W-1:0]  pb_idx,
  output logic [PADDR_W-1:0]  pd_idx,
  output logic [PADDR_W-1:0]  pw_idx,
  output logic                le_out,
  output logic [CWP_W-1:0]    cwp,
  output logic [NWINDOWS-1:0] wim,
  output logic                trap,
  output logic [1:0]          trap_type,
  output logic [7:0]          ovf_cnt,
  output logic [7:0]          unf_cnt
);

  typedef enum logic [0:0] {StRun, StTrap} state_e;

  localparam logic [CWP_W-1:0] CwpMax = CWP_W'(NWINDOWS - 1);
  // One extra bit so the range check also works when 2^CWP_W == NWINDOWS.
  localparam logic [CWP_W:0]   NWin   = (CWP_W + 1)'(NWINDOWS);

  state_e state;

  function automatic logic [CWP_W-1:0] wrap_dec(input logic [CWP_W-1:0] w);
    return (w == '0) ? CwpMax : w - CWP_W'(1);
  endfunction

  function automatic logic [CWP_W-1:0] wrap_inc(input logic [CWP_W-1:0] w);
    return (w == CwpMax) ? '0 : w + CWP_W'(1);
  endfunction

  function automatic logic [PADDR_W-1:0] base(input logic [CWP_W-1:0] w);
    return PADDR_W'(8) + (PADDR_W'(w) << 4);
  endfunction

  function automatic logic [PADDR_W-1:0] map_reg(input logic [4:0]       r,
                                                 input logic [CWP_W-1:0] w);
    logic [PADDR_W-1:0] off;
    off = PADDR_W'(r[2:0]);
    case (r[4:3])
      2'b00:   return PADDR_W'(r);                        // globals
      2'b01:   return base(wrap_dec(w)) + off;            // outs = ins of w-1
      2'b10:   return base(w) + PADDR_W'(8) + off;        // locals
      default: return base(w) + off;                      // ins
    endcase
  endfunction

  logic [CWP_W-1:0]    cwp_dec, cwp_inc, ncwp, wcwp;
  logic [NWINDOWS-1:0] wim_dec_shr, wim_inc_shr;
  logic                in_run, move_req, ovf_det, unf_det, trap_det, accept;

  always_comb begin
    cwp_dec     = wrap_dec(cwp);
    cwp_inc     = wrap_inc(cwp);
    // Shift instead of bit-select so CWP_W may exceed $clog2(NWINDOWS).
    wim_dec_shr = wim >> cwp_dec;
    wim_inc_shr = wim >> cwp_inc;
    in_run      = (state == StRun);
    // A CWP load wins over SAVE/RESTORE and suppresses the trap check.
    move_req    = in_run & ~cwp_we;
    ovf_det     = move_req & save & ~restore & wim_dec_shr[0];
    unf_det     = move_req & restore & ~save & wim_inc_shr[0];
    trap_det    = ovf_det | unf_det;
    accept      = move_req & (save ^ restore) & ~trap_det;
    ncwp        = save ? cwp_dec : cwp_inc;
    // Destination is written in the window being entered.
    wcwp        = accept ? ncwp : cwp;
    le_out      = we_in & in_run & ~trap_det;
    pa_idx      = map_reg(rs1, cwp);
    pb_idx      = map_reg(rs2, cwp);
    pd_idx      = map_reg(rs3, cwp);
    pw_idx      = map_reg(rd, wcwp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StRun;
      cwp       <= '0;
      wim       <= '0;
      trap      <= 1'b0;
      trap_type <= 2'b00;
    end else begin
      if (wim_we) begin
        wim <= wim_in;
      end
      if (cwp_we) begin
        if ({1'b0, cwp_in} < NWin) begin
          cwp <= cwp_in;
        end
      end else if (accept) begin
        cwp <= ncwp;
      end
      unique case (state)
        StRun: begin
          if (trap_det) begin
            state     <= StTrap;
            trap      <= 1'b1;
            trap_type <= ovf_det ? 2'b01 : 2'b10;
          end
        end
        StTrap: begin
          if (trap_ack) begin
            state     <= StRun;
            trap      <= 1'b0;
            trap_type <= 2'b00;
          end
        end
        default: state <= StRun;
      endcase
    end
  end

`ifdef RWM_TRAP_CNT_EN
  logic [7:0] ovf_cnt_q, unf_cnt_q;

  // ovf_det/unf_det are only asserted in RUN, so each fires once per trap entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt_q <= 8'd0;
      unf_cnt_q <= 8'd0;
    end else begin
      if (ovf_det && ovf_cnt_q != 8'hFF) begin
        ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
      if (unf_det && unf_cnt_q != 8'hFF) begin
        unf_cnt_q <= unf_cnt_q + 8'd1;
      end
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign unf_cnt = unf_cnt_q;
`else
  assign ovf_cnt = 8'd0;
  assign unf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_register_window_mapper.sv
// Self-checking bench for register_window_mapper (NWINDOWS=8). CWP_W is 4 so
// that an out-of-range cwp_in (9) can actually be driven.

module tb_register_window_mapper;

  localparam int unsigned NW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = 8;
`ifdef RWM_TRAP_CNT_EN
  localparam logic [31:0] CntOn = 32'd1;
`else
  localparam logic [31:0] CntOn = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs1, rs2, rs3, rd;
  logic          we_in, save, restore, cwp_we, wim_we, trap_ack;
  logic [CW-1:0] cwp_in;
  logic [NW-1:0] wim_in;
  logic [PW-1:0] pa_idx, pb_idx, pd_idx, pw_idx;
  logic          le_out, trap;
  logic [CW-1:0] cwp;
  logic [NW-1:0] wim;
  logic [1:0]    trap_type;
  logic [7:0]    ovf_cnt, unf_cnt;

  logic [31:0] exp_q[$];
  logic [31:0] e;
  int          n_pass = 0;
  int          n_total = 0;

  register_window_mapper #(.NWINDOWS(NW), .CWP_W(CW), .PADDR_W(PW)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rs3(rs3), .rd(rd),
    .we_in(we_in), .save(save), .restore(restore), .cwp_we(cwp_we), .cwp_in(cwp_in),
    .wim_we(wim_we), .wim_in(wim_in), .trap_ack(trap_ack),
    .pa_idx(pa_idx), .pb_idx(pb_idx), .pd_idx(pd_idx), .pw_idx(pw_idx),
    .le_out(le_out), .cwp(cwp), .wim(wim), .trap(trap), .trap_type(trap_type),
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  always #5 clk = ~clk;

  // Reference mapping written arithmetically from the register-window layout.
  function automatic logic [31:0] ref_idx(input int r, input int w);
    if (r < 8)       return 32'(r);
    else if (r < 16) return 32'(8 + 16 * ((w + NW - 1) % NW) + (r - 8));
    else if (r < 24) return 32'(8 + 16 * w + 8 + (r - 16));
    else             return 32'(8 + 16 * w + (r - 24));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; rs3 = 0; rd = 0;
    we_in = 0; save = 0; restore = 0; cwp_we = 0; cwp_in = 0;
    wim_we = 0; wim_in = 0; trap_ack = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(cwp) !== e) $display("FAIL reset_cwp got %0d want %0d", cwp, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(wim) !== e) $display("FAIL reset_wim got %0h want %0h", wim, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(trap) !== e) $display("FAIL reset_trap got %0d want %0d", trap, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(trap_type) !== e) $display("FAIL reset_ttype got %0d want %0d", trap_type, e);
    else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(ovf_cnt) !== e) $display("FAIL reset_ovf got %0d want %0d", ovf_cnt, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(unf_cnt) !== e) $display("FAIL reset_unf got %0d want %0d", unf_cnt, e); else n_pass++;
  endtask

  task automatic test_map_basic();
    rs1 = 5'd0; rs2 = 5'd16; rs3 = 5'd24; rd = 5'd8;
    exp_q.push_back(0); exp_q.push_back(16); exp_q.push_back(8); exp_q.push_back(120);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(pa_idx) !== e) $display("FAIL map_pa got %0d want %0d", pa_idx, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(pb_idx) !== e) $display("FAIL map_pb got %0d want %0d", pb_idx, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(pd_idx) !== e) $display("FAIL map_pd got %0d want %0d", pd_idx, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(pw_idx) !== e) $display("FAIL map_pw got %0d want %0d", pw_idx, e); else n_pass++;
  endtask

  // Every window (including the wrap windows 0 and 7) with random registers.
  task automatic test_map_sweep();
    for (int i = 0; i < 16; i++) begin
      int w;
      int r1, r2, r3, r4;
      w = i % NW;
      cwp_we = 1'b1; cwp_in = CW'(w);
      step();
      cwp_we = 1'b0;
      r1 = $urandom_range(0, 31); r2 = $urandom_range(0, 31);
      r3 = $urandom_range(0, 31); r4 = $urandom_range(0, 31);
      rs1 = 5'(r1); rs2 = 5'(r2); rs3 = 5'(r3); rd = 5'(r4);
      exp_q.push_back(ref_idx(r1, w)); exp_q.push_back(ref_idx(r2, w));
      exp_q.push_back(ref_idx(r3, w)); exp_q.push_back(ref_idx(r4, w));
      #1;
      n_total++; e = exp_q.pop_front();
      if (32'(pa_idx) !== e) $display("FAIL sweep_pa w=%0d r=%0d got %0d want %0d",
                                      w, r1, pa_idx, e); else n_pass++;
      n_total++; e = exp_q.pop_front();
      if (32'(pb_idx) !== e) $display("FAIL sweep_pb w=%0d r=%0d got %0d want %0d",
                                      w, r2, pb_idx, e); else n_pass++;
      n_total++; e = exp_q.pop_front();
      if (32'(pd_idx) !== e) $display("FAIL sweep_pd w=%0d r=%0d got %0d want %0d",
                                      w, r3, pd_idx, e); else n_pass++;
      n_total++; e = exp_q.pop_front();
      if (32'(pw_idx) !== e) $display("FAIL sweep_pw w=%0d r=%0d got %0d want %0d",
                                      w, r4, pw_idx, e); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_save_restore();
    cwp_we = 1'b1; cwp_in = 0;
    step();
    cwp_we = 1'b0;
    save = 1'b1; we_in = 1'b1; rd = 5'd24;
    exp_q.push_back(120); exp_q.push_back(1);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(pw_idx) !== e) $display("FAIL save_pw got %0d want %0d", pw_idx, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(le_out) !== e) $display("FAIL save_le got %0d want %0d", le_out, e); else n_pass++;
    step();
    save = 1'b0; we_in = 1'b0; rs1 = 5'd24;
    exp_q.push_back(7); exp_q.push_back(120);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(cwp) !== e) $display("FAIL save_cwp got %0d want %0d", cwp, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(pa_idx) !== e) $display("FAIL save_alias got %0d want %0d", pa_idx, e); else n_pass++;
    // RESTORE from 7 wraps to 0; the destination maps into window 0.
    restore = 1'b1; we_in = 1'b1; rd = 5'd24;
    exp_q.push_back(8); exp_q.push_back(1);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(pw_idx) !== e) $display("FAIL rest_pw got %0d want %0d", pw_idx, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(le_out) !== e) $display("FAIL rest_le got %0d want %0d", le_out, e); else n_pass++;
    step();
    idle_inputs();
    exp_q.push_back(0);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(cwp) !== e) $display("FAIL rest_cwp got %0d want %0d", cwp, e); else n_pass++;
  endtask

  task automatic test_overflow();
    wim_we = 1'b1; wim_in = 8'h80;
    step();
    wim_we = 1'b0;
    save = 1'b1; we_in = 1'b1;
    exp_q.push_back(0);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(le_out) !== e) $display("FAIL ovf_le got %0d want %0d", le_out, e); else n_pass++;
    step();
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(trap) !== e) $display("FAIL ovf_trap got %0d want %0d", trap, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(trap_type) !== e) $display("FAIL ovf_ttype got %0d want %0d", trap_type, e);
    else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(cwp) !== e) $display("FAIL ovf_cwp got %0d want %0d", cwp, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(le_out) !== e) $display("FAIL ovf_trap_le got %0d want %0d", le_out, e); else n_pass++;
    step();
    exp_q.push_back(0); exp_q.push_back(1);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(cwp) !== e) $display("FAIL ovf_ign_cwp got %0d want %0d", cwp, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(trap) !== e) $display("FAIL ovf_hold got %0d want %0d", trap, e); else n_pass++;
    save = 1'b0; we_in = 1'b0; trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(CntOn);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(trap) !== e) $display("FAIL ovf_ack got %0d want %0d", trap, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(trap_type) !== e) $display("FAIL ovf_ack_tt got %0d want %0d", trap_type, e);
    else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(ovf_cnt) !== e) $display("FAIL ovf_cnt got %0d want %0d", ovf_cnt, e); else n_pass++;
  endtask

  task automatic test_underflow();
    cwp_we = 1'b1; cwp_in = 7; wim_we = 1'b1; wim_in = 8'h01;
    step();
    cwp_we = 1'b0; wim_we = 1'b0;
    restore = 1'b1; we_in = 1'b1;
    exp_q.push_back(0);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(le_out) !== e) $display("FAIL unf_le got %0d want %0d", le_out, e); else n_pass++;
    step();
    restore = 1'b0; we_in = 1'b0;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(7); exp_q.push_back(CntOn);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(trap) !== e) $display("FAIL unf_trap got %0d want %0d", trap, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(trap_type) !== e) $display("FAIL unf_ttype got %0d want %0d", trap_type, e);
    else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(cwp) !== e) $display("FAIL unf_cwp got %0d want %0d", cwp, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(unf_cnt) !== e) $display("FAIL unf_cnt got %0d want %0d", unf_cnt, e); else n_pass++;
    trap_ack = 1'b1; wim_we = 1'b1; wim_in = 8'h00;
    step();
    trap_ack = 1'b0; wim_we = 1'b0;
    cwp_we = 1'b1; cwp_in = 4'd9;
    step();
    cwp_we = 1'b0;
    exp_q.push_back(7); exp_q.push_back(0);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(cwp) !== e) $display("FAIL cwp_range got %0d want %0d", cwp, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(trap) !== e) $display("FAIL unf_ack got %0d want %0d", trap, e); else n_pass++;
  endtask

  task automatic test_priority();
    // All windows invalid: any trap check that is not suppressed would fire.
    wim_we = 1'b1; wim_in = 8'hFF; cwp_we = 1'b1; cwp_in = 3;
    step();
    wim_we = 1'b0; cwp_we = 1'b0;
    save = 1'b1; restore = 1'b1; we_in = 1'b1; rd = 5'd8;
    exp_q.push_back(1); exp_q.push_back(40);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(le_out) !== e) $display("FAIL both_le got %0d want %0d", le_out, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(pw_idx) !== e) $display("FAIL both_pw got %0d want %0d", pw_idx, e); else n_pass++;
    step();
    restore = 1'b0; we_in = 1'b0;
    exp_q.push_back(3); exp_q.push_back(0);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(cwp) !== e) $display("FAIL both_cwp got %0d want %0d", cwp, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(trap) !== e) $display("FAIL both_trap got %0d want %0d", trap, e); else n_pass++;
    cwp_we = 1'b1; cwp_in = 5;
    step();
    cwp_we = 1'b0; save = 1'b0;
    exp_q.push_back(5); exp_q.push_back(0);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(cwp) !== e) $display("FAIL prio_cwp got %0d want %0d", cwp, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(trap) !== e) $display("FAIL prio_trap got %0d want %0d", trap, e); else n_pass++;
  endtask

  task automatic test_reset_mid_trap();
    save = 1'b1;
    step();
    save = 1'b0;
    exp_q.push_back(1);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(trap) !== e) $display("FAIL mid_pre got %0d want %0d", trap, e); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    #1;
    n_total++; e = exp_q.pop_front();
    if (32'(trap) !== e) $display("FAIL mid_trap got %0d want %0d", trap, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(trap_type) !== e) $display("FAIL mid_tt got %0d want %0d", trap_type, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(cwp) !== e) $display("FAIL mid_cwp got %0d want %0d", cwp, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(wim) !== e) $display("FAIL mid_wim got %0h want %0h", wim, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(ovf_cnt) !== e) $display("FAIL mid_ovf got %0d want %0d", ovf_cnt, e); else n_pass++;
    n_total++; e = exp_q.pop_front();
    if (32'(unf_cnt) !== e) $display("FAIL mid_unf got %0d want %0d", unf_cnt, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_map_basic();
    test_map_sweep();
    test_save_restore();
    test_overflow();
    test_underflow();
    test_priority();
    test_reset_mid_trap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
